uart_tx_sched: RTL and testbench

Transmit scheduler for the UART transmitter. It arbitrates byte write requests from `NUM_REQ` requesters round-robin and buffers accepted bytes in an internal FIFO. It launches one character at a time into the transmitter through its `start_tx`/`tx_done` handshake, and holds the data word stable for the whole frame. It sits between the APB register block (plus any other byte sources) and `uart_tx`.

---
 rtl/uart_tx_sched.sv | 89 ++++++++
 tb/tb_uart_tx_sched.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin byte arbiter, FIFO and one-character-at-a-time launcher for uart_tx
module uart_tx_sched #(
  parameter int NUM_REQ    = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [8*NUM_REQ-1:0] req_data_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  input  logic                 tx_en_i,
  input  logic                 flush_i,
  output logic [31:0]          tx_data_o,
  output logic                 start_tx_o,
  input  logic                 tx_done_i,
  output logic [CW-1:0]        fifo_count_o,
  output logic                 fifo_full_o,
  output logic                 fifo_empty_o,
  output logic                 busy_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_ACK, WAIT_DONE} state_t;
  state_t state, state_d;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [PW-1:0] rr_ptr, gidx;
  logic [NUM_REQ-1:0] grant;
  logic found, push, pop;
  always_comb begin
    grant = '0;
    gidx = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++)
      if (!found && req_valid_i[(int'(rr_ptr) + k) % NUM_REQ]) begin
        found = 1'b1;
        gidx = PW'((int'(rr_ptr) + k) % NUM_REQ);
        grant[(int'(rr_ptr) + k) % NUM_REQ] = 1'b1;
      end
    req_ready_o = (fifo_full_o || flush_i) ? '0 : grant;
  end
  assign push         = |(req_valid_i & req_ready_o);
  assign pop          = state == IDLE && !fifo_empty_o && tx_en_i && tx_done_i && !flush_i;
  assign fifo_count_o = count;
  assign fifo_full_o  = count == CW'(FIFO_DEPTH);
  assign fifo_empty_o = count == '0;
  assign busy_o       = state != IDLE;
  assign start_tx_o   = state == LAUNCH;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= req_data_i[8*gidx +: 8];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rr_ptr    <= '0;
      tx_data_o <= '0;
    end else begin
      state <= state_d;
      if (push) rr_ptr <= PW'((int'(gidx) + 1) % NUM_REQ);
      if (flush_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop) begin
          rd_ptr    <= rd_ptr + 1'b1;
          tx_data_o <= {24'd0, mem[rd_ptr]};
        end
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end
  // the launch pulse is a full state so the transmitter sees tx_data_o settled before start
  always_comb begin
    state_d = state;
    case (state)
      IDLE:      state_d = pop ? LAUNCH : IDLE;
      LAUNCH:    state_d = WAIT_ACK;
      WAIT_ACK:  state_d = tx_done_i ? WAIT_ACK : WAIT_DONE;
      WAIT_DONE: state_d = tx_done_i ? IDLE : WAIT_DONE;
      default:   state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: table-driven arbitration vectors plus directed launch, flush, wrap and reset sequences
module tb_uart_tx_sched;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid_i;
  logic [15:0] req_data_i;
  logic [1:0]  req_ready_o;
  logic        tx_en_i, flush_i, tx_done_i;
  logic [31:0] tx_data_o;
  logic        start_tx_o;
  logic [3:0]  fifo_count_o;
  logic        fifo_full_o, fifo_empty_o, busy_o;
  int tests = 0;
  int fails = 0;
  logic [7:0] q[$];
  typedef struct {
    logic [1:0] valid;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [1:0] ready;
    logic [3:0] count;
    logic       full;
  } vec_t;
  vec_t tbl[10];

  uart_tx_sched #(.NUM_REQ(2), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid_i), .req_data_i(req_data_i),
    .req_ready_o(req_ready_o), .tx_en_i(tx_en_i), .flush_i(flush_i), .tx_data_o(tx_data_o),
    .start_tx_o(start_tx_o), .tx_done_i(tx_done_i), .fifo_count_o(fifo_count_o),
    .fifo_full_o(fifo_full_o), .fifo_empty_o(fifo_empty_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    req_valid_i = 2'b01;
    req_data_i[7:0] = b;
    #1;
    chk("push_ready", 32'(req_ready_o), 32'h1);
    tick;
    req_valid_i = '0;
    q.push_back(b);
    #1;
  endtask

  task automatic frame(input int len);
    int n;
    logic [7:0] b;
    b = q.size() > 0 ? q.pop_front() : 8'h00;
    tx_en_i = 1'b1;
    n = 0;
    do begin
      tick;
      #1;
      n++;
    end while (!start_tx_o && n < 20);
    tx_en_i = 1'b0;
    chk("launch", 32'(start_tx_o), 32'h1);
    chk("tx_data", tx_data_o, {24'd0, b});
    tx_done_i = 1'b0;
    repeat (len) tick;
    tx_done_i = 1'b1;
    tick;
    #1;
    chk("frame_idle", 32'(busy_o), 32'h0);
  endtask

  task automatic no_start(input int cyc, input string name);
    int bad;
    bad = 0;
    repeat (cyc) begin
      tick;
      #1;
      if (start_tx_o) bad++;
    end
    chk(name, bad, 0);
  endtask

  initial begin
    int bad;
    rst_n = 1'b0;
    req_valid_i = '0;
    req_data_i = '0;
    tx_en_i = 1'b0;
    flush_i = 1'b0;
    tx_done_i = 1'b1;
    tick;
    tick;
    #1;
    chk("rst_start", 32'(start_tx_o), 32'h0);
    chk("rst_data", tx_data_o, 32'h0);
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_count", 32'(fifo_count_o), 32'h0);
    chk("rst_empty", 32'(fifo_empty_o), 32'h1);
    chk("rst_full", 32'(fifo_full_o), 32'h0);
    rst_n = 1'b1;
    // round-robin fill with no launches; rr starts at requester 0
    tbl[0] = '{2'b11, 8'hA0, 8'hB0, 2'b01, 4'd0, 1'b0};
    tbl[1] = '{2'b11, 8'hA1, 8'hB0, 2'b10, 4'd1, 1'b0};
    tbl[2] = '{2'b11, 8'hA1, 8'hB1, 2'b01, 4'd2, 1'b0};
    tbl[3] = '{2'b11, 8'hA2, 8'hB1, 2'b10, 4'd3, 1'b0};
    tbl[4] = '{2'b10, 8'hA2, 8'hB2, 2'b10, 4'd4, 1'b0};
    tbl[5] = '{2'b01, 8'hA2, 8'hB3, 2'b01, 4'd5, 1'b0};
    tbl[6] = '{2'b00, 8'hA3, 8'hB3, 2'b00, 4'd6, 1'b0};
    tbl[7] = '{2'b11, 8'hA3, 8'hB3, 2'b10, 4'd6, 1'b0};
    tbl[8] = '{2'b11, 8'hA3, 8'hB4, 2'b01, 4'd7, 1'b0};
    tbl[9] = '{2'b11, 8'hA4, 8'hB4, 2'b00, 4'd8, 1'b1};
    for (int i = 0; i < 10; i++) begin
      req_valid_i = tbl[i].valid;
      req_data_i = {tbl[i].d1, tbl[i].d0};
      #1;
      chk($sformatf("rr_ready[%0d]", i), 32'(req_ready_o), 32'(tbl[i].ready));
      chk($sformatf("rr_count[%0d]", i), 32'(fifo_count_o), 32'(tbl[i].count));
      chk($sformatf("rr_full[%0d]", i), 32'(fifo_full_o), 32'(tbl[i].full));
      if (tbl[i].ready[0]) q.push_back(tbl[i].d0);
      else if (tbl[i].ready[1]) q.push_back(tbl[i].d1);
      tick;
    end
    req_valid_i = '0;
    #1;
    chk("rr_count_final", 32'(fifo_count_o), 32'h8);
    repeat (8) frame(3);
    chk("rr_drained", 32'(fifo_empty_o), 32'h1);
    // single byte: push at E0, pop at E1, start pulse E1..E2
    tx_en_i = 1'b1;
    req_valid_i = 2'b01;
    req_data_i[7:0] = 8'h5A;
    #1;
    chk("sb_ready", 32'(req_ready_o), 32'h1);
    tick;
    req_valid_i = '0;
    #1;
    chk("sb_count", 32'(fifo_count_o), 32'h1);
    chk("sb_nostart", 32'(start_tx_o), 32'h0);
    tick;
    #1;
    chk("sb_start", 32'(start_tx_o), 32'h1);
    chk("sb_data", tx_data_o, 32'h0000005A);
    chk("sb_busy", 32'(busy_o), 32'h1);
    chk("sb_empty", 32'(fifo_empty_o), 32'h1);
    tick;
    #1;
    chk("sb_pulse_width", 32'(start_tx_o), 32'h0);
    tx_done_i = 1'b0;
    tick;
    bad = 0;
    repeat (100) begin
      tick;
      #1;
      if (!busy_o || tx_data_o !== 32'h5A || start_tx_o) bad++;
    end
    chk("sb_busy_hold", bad, 0);
    tx_done_i = 1'b1;
    tick;
    #1;
    chk("sb_idle", 32'(busy_o), 32'h0);
    chk("sb_empty_end", 32'(fifo_empty_o), 32'h1);
    tx_en_i = 1'b0;
    // simultaneous push and pop at count 3
    push_byte(8'hC1);
    push_byte(8'hC2);
    push_byte(8'hC3);
    chk("pp_count_pre", 32'(fifo_count_o), 32'h3);
    tx_en_i = 1'b1;
    req_valid_i = 2'b01;
    req_data_i[7:0] = 8'hC4;
    #1;
    chk("pp_ready", 32'(req_ready_o), 32'h1);
    tick;
    req_valid_i = '0;
    tx_en_i = 1'b0;
    q.push_back(8'hC4);
    void'(q.pop_front());
    #1;
    chk("pp_count", 32'(fifo_count_o), 32'h3);
    chk("pp_start", 32'(start_tx_o), 32'h1);
    chk("pp_data", tx_data_o, 32'hC1);
    tx_done_i = 1'b0;
    repeat (3) tick;
    tx_done_i = 1'b1;
    tick;
    #1;
    repeat (3) frame(2);
    // launch gated by tx_en
    push_byte(8'hE1);
    push_byte(8'hE2);
    no_start(10, "en_gate");
    frame(2);
    frame(2);
    // full boundary and pointer wrap over 20 pushes
    for (int i = 0; i < 8; i++) push_byte(8'hD0 + 8'(i));
    chk("wrap_full0", 32'(fifo_full_o), 32'h1);
    chk("wrap_count8", 32'(fifo_count_o), 32'h8);
    req_valid_i = 2'b11;
    #1;
    chk("wrap_ready_full", 32'(req_ready_o), 32'h0);
    req_valid_i = '0;
    for (int i = 0; i < 12; i++) begin
      frame(2);
      chk("wrap_notfull", 32'(fifo_full_o), 32'h0);
      chk("wrap_count7", 32'(fifo_count_o), 32'h7);
      push_byte(8'h10 + 8'(i));
      chk("wrap_full", 32'(fifo_full_o), 32'h1);
    end
    repeat (8) frame(2);
    chk("wrap_empty", 32'(fifo_empty_o), 32'h1);
    // flush with 5 queued during a frame
    for (int i = 0; i < 5; i++) push_byte(8'hF0 + 8'(i));
    tx_en_i = 1'b1;
    tick;
    #1;
    chk("fl_start", 32'(start_tx_o), 32'h1);
    chk("fl_data", tx_data_o, 32'hF0);
    tx_done_i = 1'b0;
    tick;
    push_byte(8'hF5);
    chk("fl_count5", 32'(fifo_count_o), 32'h5);
    flush_i = 1'b1;
    req_valid_i = 2'b11;
    #1;
    chk("fl_ready", 32'(req_ready_o), 32'h0);
    tick;
    flush_i = 1'b0;
    req_valid_i = '0;
    #1;
    chk("fl_count", 32'(fifo_count_o), 32'h0);
    chk("fl_empty", 32'(fifo_empty_o), 32'h1);
    chk("fl_data_held", tx_data_o, 32'hF0);
    chk("fl_busy", 32'(busy_o), 32'h1);
    q.delete();
    repeat (3) tick;
    tx_done_i = 1'b1;
    no_start(10, "fl_nolaunch");
    chk("fl_idle", 32'(busy_o), 32'h0);
    tx_en_i = 1'b0;
    // reset mid-frame with 4 queued; rr left at 1 by requester-0 pushes
    for (int i = 0; i < 5; i++) push_byte(8'h80 + 8'(i));
    tx_en_i = 1'b1;
    tick;
    #1;
    chk("rs_start", 32'(start_tx_o), 32'h1);
    tx_en_i = 1'b0;
    tx_done_i = 1'b0;
    tick;
    tick;
    #1;
    chk("rs_count4", 32'(fifo_count_o), 32'h4);
    chk("rs_busy", 32'(busy_o), 32'h1);
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    #1;
    chk("rs_start0", 32'(start_tx_o), 32'h0);
    chk("rs_data0", tx_data_o, 32'h0);
    chk("rs_busy0", 32'(busy_o), 32'h0);
    chk("rs_count0", 32'(fifo_count_o), 32'h0);
    chk("rs_empty", 32'(fifo_empty_o), 32'h1);
    chk("rs_full", 32'(fifo_full_o), 32'h0);
    tx_done_i = 1'b1;
    tx_en_i = 1'b1;
    no_start(10, "rs_nolaunch");
    q.delete();
    req_valid_i = 2'b11;
    req_data_i = {8'h66, 8'h55};
    #1;
    chk("rs_rr_ptr", 32'(req_ready_o), 32'h1);
    tick;
    req_valid_i = '0;
    q.push_back(8'h55);
    frame(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
